mod5_sched: RTL and testbench
=============================

MOD5_SCHED -- requirements
Module: mod5_sched

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 8, meaning the maximum number of 16-bit words in one operand (range 1..255).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports in_valid  input  2, in_word0  input  16, in_word1  input  16 and in_last  input  2: per-requester word-valid, word data and last-word flag (bit i belongs to requester i).
REQ-005 The block SHALL have port in_ready  output  2  per-requester word accept; a word transfers when in_valid[i] and in_ready[i] are both 1.
REQ-006 The block SHALL have ports out_valid  output  1, out_rem  output  3 (operand mod 5, 0..4), out_id  output  1 (requester served) and out_err  output  1 (operand truncated at MAX_WORDS).
REQ-007 The block SHALL have port out_ready  input  1  result accept.

Function
REQ-008 Operand value SHALL be the words concatenated most-significant word first; since 2^16 mod 5 = 1, the remainder SHALL equal (sum of per-word residues) mod 5.
REQ-009 The FSM SHALL have states IDLE, BUSY, DRAIN and DONE.
REQ-010 In IDLE, with any in_valid set, the block SHALL grant one requester: the only valid one, or on a tie the one not served last (round-robin pointer).
REQ-011 The grant SHALL lock to that requester until its last word is accepted; the other requester's in_ready SHALL stay 0.
REQ-012 In IDLE and BUSY, in_ready[g] SHALL be 1 for the granted requester g; a word SHALL be accepted in the cycle the grant is made.
REQ-013 Each accepted word SHALL be registered in stage S1.
REQ-014 In the next cycle, the residue of the S1 word SHALL be added to a 3-bit accumulator modulo 5; the accumulator SHALL be cleared when a new grant is made.
REQ-015 Acceptance of a word with in_last=1 SHALL move the FSM to DRAIN; in_ready SHALL be 0 from the following cycle.
REQ-016 DRAIN SHALL last exactly 1 cycle, after which the FSM enters DONE; out_valid SHALL rise 2 cycles after the last-word acceptance edge.
REQ-017 In DONE, out_valid=1, and out_rem, out_id and out_err SHALL hold stable until out_ready=1.
REQ-018 After the out_valid & out_ready handshake, the round-robin pointer SHALL toggle to the other requester and the FSM SHALL return to IDLE; no grant SHALL be made in the handshake cycle.
REQ-019 A word counter SHALL count accepted words of the current operand.
REQ-020 If the MAX_WORDS-th word is accepted with in_last=0, the block SHALL treat it as last and set out_err=1; a word with in_last=1 at exactly MAX_WORDS SHALL give out_err=0.
REQ-021 A gap cycle (in_valid[g]=0 during BUSY) SHALL leave the accumulator and the counter unchanged.
REQ-022 The residue of a 16-bit word SHALL be exact for all 65536 values.

Reset
REQ-023 rst=1 SHALL asynchronously force: FSM IDLE, round-robin pointer to requester 0, accumulator 0, word counter 0, S1 valid 0, in_ready 0, out_valid 0, out_rem 0, out_id 0, out_err 0.
REQ-024 Reset mid-operand SHALL discard the partial operand; no result SHALL be emitted for it.
REQ-025 After rst falls, the first grant SHALL occur no earlier than the first clock edge.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the 16-bit word width and the modulus constant 5.
REQ-027 The 16-bit residue function SHALL be one combinational sub-module, mod5_res16 (16-bit in, 3-bit out), instantiated once and shared by both requesters.

Verification
REQ-028 The bench SHALL cover: requester 0, single word 0xFFFF, last=1 -> out_rem=0, out_id=0, out_err=0, out_valid 2 cycles after acceptance.
REQ-029 The bench SHALL cover: requester 1, words 0x0001 then 0x0003 (value 65539) -> out_rem=4, out_id=1.
REQ-030 The bench SHALL cover: both requesters valid immediately after reset, each sending one word 0x0007 -> requester 0 served first (rem 2), then requester 1 (rem 2).
REQ-031 The bench SHALL cover: out_ready held 0 for 5 cycles -> out_valid stays 1 with stable outputs, and in_ready stays 0 throughout.
REQ-032 The bench SHALL cover: MAX_WORDS=8 with 8 words of 0x0001 and no last flag -> out_rem=3, out_err=1.
REQ-033 The bench SHALL cover: rst asserted after 2 of 3 words -> no out_valid, pointer reset to requester 0, and a following operand is correct.

Source files
------------

// File: rtl/mod5_sched_pkg.sv
// Shared types and constants for the mod-5 operand scheduler.
// Combinational helpers only; no latency, no backpressure.
// Holds FSM encoding, word width, modulus and modular add.
package mod5_sched_pkg;

    localparam int WORD_W = 16;
    localparam int MOD    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Both operands are already reduced (0..4), so one conditional subtract suffices.
    function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'(MOD)) begin
            s = s - 4'(MOD);
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/mod5_res16.sv
// Exact residue mod 5 of a 16-bit word.
// Purely combinational, zero latency.
// No handshake; output follows input.
module mod5_res16
    import mod5_sched_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [2:0]        res
);

    logic [5:0] nib_sum;
    logic [4:0] fold;

    // 16 mod 5 = 1, so every nibble carries weight 1 in the residue.
    always_comb begin
        nib_sum = {2'b00, word[3:0]}  + {2'b00, word[7:4]} +
                  {2'b00, word[11:8]} + {2'b00, word[15:12]};
        fold    = {3'b000, nib_sum[5:4]} + {1'b0, nib_sum[3:0]};
        if (fold >= 5'd15) begin
            res = 3'(fold - 5'd15);
        end else if (fold >= 5'd10) begin
            res = 3'(fold - 5'd10);
        end else if (fold >= 5'd5) begin
            res = 3'(fold - 5'd5);
        end else begin
            res = fold[2:0];
        end
    end

endmodule

// File: rtl/mod5_sched.sv
// Two-requester round-robin scheduler computing (multi-word operand) mod 5.
// Latency: result valid 2 cycles after the last-word acceptance edge.
// Backpressure: result held in DONE until out_ready; no words accepted meanwhile.
module mod5_sched
    import mod5_sched_pkg::*;
#(
    parameter int MAX_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_valid,
    input  logic [WORD_W-1:0] in_word0,
    input  logic [WORD_W-1:0] in_word1,
    input  logic [1:0]        in_last,
    output logic [1:0]        in_ready,
    output logic              out_valid,
    output logic [2:0]        out_rem,
    output logic              out_id,
    output logic              out_err,
    input  logic              out_ready
);

    state_t            state;
    state_t            state_nxt;
    logic              rr_q;
    logic              gnt_q;
    logic              pick;
    logic              cur;
    logic              cur_last;
    logic [WORD_W-1:0] cur_dat;
    logic              accept;
    logic              at_max;
    logic              end_word;
    logic [7:0]        cnt;
    logic [7:0]        cnt_base;
    logic              err_q;
    logic              s1_vld;
    logic [WORD_W-1:0] s1_dat;
    logic [2:0]        s1_res;
    logic [2:0]        acc;
    logic [2:0]        acc_nxt;

    mod5_res16 u_res (
        .word (s1_dat),
        .res  (s1_res)
    );

    always_comb begin
        pick     = (in_valid == 2'b11) ? rr_q : in_valid[1];
        cur      = (state == IDLE) ? pick : gnt_q;
        cur_dat  = cur ? in_word1 : in_word0;
        cur_last = in_last[cur];
        cnt_base = (state == IDLE) ? 8'd0 : cnt;
        at_max   = (cnt_base == 8'(MAX_WORDS - 1));
        accept   = |(in_ready & in_valid);
        end_word = accept && (cur_last || at_max);
        acc_nxt  = s1_vld ? add_mod5(acc, s1_res) : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = end_word ? DRAIN : BUSY;
            BUSY:    if (end_word) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rst gates in_ready so nothing is offered while reset is held.
    always_comb begin
        in_ready  = 2'b00;
        out_valid = 1'b0;
        case (state)
            IDLE:    if (!rst && (|in_valid)) in_ready[pick] = 1'b1;
            BUSY:    in_ready[gnt_q] = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            cnt     <= 8'd0;
            err_q   <= 1'b0;
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            acc     <= 3'd0;
            out_rem <= 3'd0;
            out_id  <= 1'b0;
            out_err <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_dat <= cur_dat;
                cnt    <= cnt_base + 8'd1;
                err_q  <= at_max && !cur_last;
            end
            if (accept && state == IDLE) begin
                gnt_q <= cur;
                acc   <= 3'd0;
            end else begin
                acc   <= acc_nxt;
            end
            if (state == DRAIN) begin
                out_rem <= acc_nxt;
                out_id  <= gnt_q;
                out_err <= err_q;
            end
            if (state == DONE && out_ready) begin
                rr_q <= ~out_id;
            end
        end
    end

endmodule

// File: tb/tb_mod5_sched.sv
// Directed bench for mod5_sched with a result scoreboard.
// Stimulus pushes expected results; a negedge monitor pops on each handshake.
module tb_mod5_sched;

    typedef struct packed {
        logic [2:0] rem;
        logic       id;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_valid = 2'b00;
    logic [15:0] in_word0 = 16'h0;
    logic [15:0] in_word1 = 16'h0;
    logic [1:0]  in_last = 2'b00;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [2:0]  out_rem;
    logic        out_id;
    logic        out_err;
    logic        out_ready = 1'b1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    mod5_sched #(.MAX_WORDS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_word0  (in_word0),
        .in_word1  (in_word1),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_rem   (out_rem),
        .out_id    (out_id),
        .out_err   (out_err),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got rem=%0d id=%0d err=%0d, expected none",
                         out_rem, out_id, out_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_rem, out_id, out_err} !== mon_e) begin
                    errors++;
                    $display("FAIL result: got rem=%0d id=%0d err=%0d, expected rem=%0d id=%0d err=%0d",
                             out_rem, out_id, out_err, mon_e.rem, mon_e.id, mon_e.err);
                end
            end
        end
    end

    task automatic push(input logic [2:0] rem, input logic id, input logic err);
        exp_q.push_back('{rem: rem, id: id, err: err});
    endtask

    task automatic send(input int id, input logic [15:0] d, input logic l);
        int n;
        in_valid[id] = 1'b1;
        in_last[id]  = l;
        if (id == 0) in_word0 = d;
        else         in_word1 = d;
        n = 0;
        @(negedge clk);
        while (!in_ready[id] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("send_accept");
        @(posedge clk);
        #1;
        in_valid[id] = 1'b0;
        in_last[id]  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    // Both requesters valid with a single last word each; requester 0 must win.
    task automatic pair(input logic [15:0] w0, input logic [15:0] w1);
        int n;
        in_word0 = w0;
        in_word1 = w1;
        in_last  = 2'b11;
        in_valid = 2'b11;
        n = 0;
        @(negedge clk);
        while (!in_ready[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("pair_req0");
        chk("pair_lock_ready1", 32'(in_ready[1]), 32'd0);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("pair_req1");
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        in_last  = 2'b00;
    endtask

    initial begin
        in_valid = 2'b11;
        in_word0 = 16'h0007;
        in_word1 = 16'h0007;
        in_last  = 2'b11;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_outputs", 32'({out_valid, out_rem, out_id, out_err}), 32'd0);
        @(posedge clk);
        #1;

        // Requesters race right after reset: 7 mod 5 = 2 for both.
        push(3'd2, 1'b0, 1'b0);
        push(3'd2, 1'b1, 1'b0);
        rst = 1'b0;
        pair(16'h0007, 16'h0007);
        drain();

        // 0xFFFF mod 5 = 0; out_valid seen on the second sample after acceptance.
        push(3'd0, 1'b0, 1'b0);
        send(0, 16'hFFFF, 1'b1);
        @(negedge clk);
        chk("latency_drain_cycle", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_done_cycle", 32'(out_valid), 32'd1);
        drain();

        // 65539 mod 5 = 4, with gap cycles between words.
        push(3'd4, 1'b1, 1'b0);
        send(1, 16'h0001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send(1, 16'h0003, 1'b1);
        drain();

        // Result stall: 9 mod 5 = 4 held while out_ready is low.
        out_ready = 1'b0;
        push(3'd4, 1'b0, 1'b0);
        send(0, 16'h0009, 1'b1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) timeout("stall_wait");
        end
        in_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_outputs", 32'({out_valid, out_rem, out_id, out_err}), 32'({1'b1, 3'd4, 1'b0, 1'b0}));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 2'b00;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Eight words of 1 with last on the eighth: 8 mod 5 = 3, no error.
        push(3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send(1, 16'h0001, (i == 7));
        drain();

        // Eight words of 1 without last: truncated, err set.
        push(3'd3, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send(0, 16'h0001, 1'b0);
        in_valid[0] = 1'b1;
        @(negedge clk);
        chk("trunc_ready_drop", 32'(in_ready[0]), 32'd0);
        in_valid[0] = 1'b0;
        drain();

        // Reset after 2 of 3 words; pointer was on requester 1 before reset.
        send(0, 16'h0001, 1'b0);
        send(0, 16'h0001, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midreset_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        push(3'd2, 1'b0, 1'b0);
        push(3'd1, 1'b1, 1'b0);
        rst = 1'b0;
        pair(16'h000C, 16'h0010);
        drain();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
